demux_1to2_data: RTL and testbench
==================================

Name: demux_1to2_data

Overview:
- Parameterised 1-to-2 demultiplexer on a WIDTH-bit data bus.
- Steers input word i to o0 when sel=0 and to o1 when sel=1; the non-selected output is forced to zero.
- Registered variant: one clock, asynchronous active-high reset, one-cycle latency, per-output valid strobes.
- Sits in datapath fan-out points, e.g. routing a stream to one of two consumers.

Parameters:
- WIDTH, 2, data bus width in bits (legal range 1..64).
- HOLD_UNSEL, 0, 0 = non-selected output cleared to zero each valid cycle; 1 = non-selected output holds its last value.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i  input  WIDTH  data word to route.
- sel  input  1  destination select: 0 -> o0, 1 -> o1.
- i_valid  input  1  qualifies i/sel; when 0, no routing occurs.
- o0  output  WIDTH  registered output port 0.
- o1  output  WIDTH  registered output port 1.
- o0_valid  output  1  one-cycle strobe: o0 updated with new data this cycle.
- o1_valid  output  1  one-cycle strobe: o1 updated with new data this cycle.

Behaviour:
- Reset: rst=1 immediately (asynchronously) clears o0, o1, o0_valid and o1_valid to 0. Reset mid-stream discards any in-flight word. The first capture happens at the first rising clk edge after rst deasserts.
- Latency: exactly one clk cycle from i/sel/i_valid sampled at edge N to outputs valid after edge N.
- Valid cycle with sel=0:
  - o0 <= i; o0_valid <= 1; o1_valid <= 0.
  - o1 <= 0 if HOLD_UNSEL=0, else o1 unchanged.
- Valid cycle with sel=1: mirror image of the sel=0 case.
- At most one of o0_valid/o1_valid is high in any cycle.
- i_valid=0: both valid strobes <= 0. o0/o1 hold their values regardless of HOLD_UNSEL.
- Back-to-back valid words are accepted every cycle; no backpressure and no stall.
- i=0 routed is legal: the destination valid strobe distinguishes it from an idle zero.
- sel or i X/Z while i_valid=0: outputs unaffected.
- No arithmetic; data is passed bit-exact at full WIDTH with no truncation or extension.

Decomposition:
- No shared package required. A local constant for the zero word ({WIDTH{1'b0}}) is sufficient.
- Natural split: one combinational sub-module demux_1to2_comb (i, sel -> o0_next, o1_next, zero on the unselected side).
- The top level wraps demux_1to2_comb with the valid logic, the HOLD_UNSEL mux and the output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with o0=2'b11 -> o0, o1 and both valids read 0 before the next clk edge.
- sel=0 sweep, WIDTH=2, i_valid=1, i=00,01,10,11 on consecutive cycles -> one cycle later o0 follows 00,01,10,11, o1=00, o0_valid=1, o1_valid=0 each cycle.
- sel=1 sweep, same i values -> o1 follows 00,01,10,11, o0=00, o1_valid=1, o0_valid=0.
- Alternating sel every cycle with i=2'b10, then 2'b01, HOLD_UNSEL=0 -> outputs (o0,o1) = (10,00), then (00,01); valid strobes alternate.
- HOLD_UNSEL=1: send i=2'b11 to o0, then i=2'b01 to o1 -> o0 stays 11 while o1=01.
- Idle: i_valid=0 for 3 cycles with random i/sel -> o0/o1 unchanged and both valids 0 throughout.

Source files
------------

// File: rtl/demux_1to2_data_pkg.sv
// demux_1to2_data_pkg: shared types for the registered 1-to-2 data demultiplexer.
`default_nettype none

package demux_1to2_data_pkg;

  typedef enum logic {
    DEST_O0 = 1'b0,
    DEST_O1 = 1'b1
  } dest_e;

endpackage

`default_nettype wire

// File: rtl/demux_1to2_data_comb.sv
// demux_1to2_comb: combinational steering of one word to o0 or o1, zero on the other side.
`default_nettype none

module demux_1to2_comb
  import demux_1to2_data_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] i,
  input  logic             sel,
  output logic [WIDTH-1:0] o0_next,
  output logic [WIDTH-1:0] o1_next
);

  localparam logic [WIDTH-1:0] ZERO_WORD = {WIDTH{1'b0}};

  always_comb begin
    o0_next = ZERO_WORD;
    o1_next = ZERO_WORD;
    if (sel == DEST_O1) begin
      o1_next = i;
    end else begin
      o0_next = i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_1to2_data.sv
// demux_1to2_data: registered 1-to-2 demux with per-output valid strobes, one-cycle latency.
`default_nettype none

module demux_1to2_data
  import demux_1to2_data_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter bit HOLD_UNSEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic             sel,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic             o0_valid,
  output logic             o1_valid
);

  logic [WIDTH-1:0] o0_next;
  logic [WIDTH-1:0] o1_next;
  logic [WIDTH-1:0] o0_d;
  logic [WIDTH-1:0] o1_d;
  logic             o0_valid_d;
  logic             o1_valid_d;

  demux_1to2_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .i      (i),
    .sel    (sel),
    .o0_next(o0_next),
    .o1_next(o1_next)
  );

  // Idle cycles keep both words; the unselected side only updates (to zero) when not holding.
  always_comb begin
    o0_d       = o0;
    o1_d       = o1;
    o0_valid_d = 1'b0;
    o1_valid_d = 1'b0;
    if (i_valid) begin
      o0_valid_d = (sel == DEST_O0);
      o1_valid_d = (sel == DEST_O1);
      if (!HOLD_UNSEL || sel == DEST_O0) begin
        o0_d = o0_next;
      end
      if (!HOLD_UNSEL || sel == DEST_O1) begin
        o1_d = o1_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o0       <= '0;
      o1       <= '0;
      o0_valid <= 1'b0;
      o1_valid <= 1'b0;
    end else begin
      o0       <= o0_d;
      o1       <= o1_d;
      o0_valid <= o0_valid_d;
      o1_valid <= o1_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_demux_1to2_data.sv
// tb_demux_1to2_data: scoreboard bench driving a clear-unselected and a hold-unselected instance.
`default_nettype none

module tb_demux_1to2_data;

  localparam int W = 2;

  typedef struct packed {
    logic [W-1:0] o0;
    logic [W-1:0] o1;
    logic         v0;
    logic         v1;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         sel = 1'b0;
  logic         vin = 1'b0;

  logic [W-1:0] o0_w [2];
  logic [W-1:0] o1_w [2];
  logic         v0_w [2];
  logic         v1_w [2];

  exp_t         sbq [2][$];
  logic [W-1:0] model0 [2];
  logic [W-1:0] model1 [2];
  logic         done = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  demux_1to2_data #(.WIDTH(W), .HOLD_UNSEL(1'b0)) dut_clr (
    .clk(clk), .rst(rst), .i(din), .sel(sel), .i_valid(vin),
    .o0(o0_w[0]), .o1(o1_w[0]), .o0_valid(v0_w[0]), .o1_valid(v1_w[0])
  );

  demux_1to2_data #(.WIDTH(W), .HOLD_UNSEL(1'b1)) dut_hold (
    .clk(clk), .rst(rst), .i(din), .sel(sel), .i_valid(vin),
    .o0(o0_w[1]), .o1(o1_w[1]), .o0_valid(v0_w[1]), .o1_valid(v1_w[1])
  );

  // ---------------- stimulus ----------------
  task automatic send(input logic v, input logic s, input logic [W-1:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    vin = v;
    sel = s;
    din = d;
    if (v) begin
      for (int k = 0; k < 2; k++) begin
        if (s == 1'b0) begin
          model0[k] = d;
          if (k == 0) model1[k] = '0;
        end else begin
          model1[k] = d;
          if (k == 0) model0[k] = '0;
        end
        e.o0 = model0[k];
        e.o1 = model1[k];
        e.v0 = ~s;
        e.v1 = s;
        sbq[k].push_back(e);
      end
    end
  endtask

  task automatic idle_random(input int n);
    for (int c = 0; c < n; c++) send(1'b0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 3)));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      model0[k] = '0;
      model1[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Load o0=11, let it sit, then reset asynchronously mid-cycle.
    send(1'b1, 1'b0, 2'b11);
    send(1'b0, 1'b0, 2'b00);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model0[k] = '0;
      model1[k] = '0;
    end

    for (int d = 0; d < 4; d++) send(1'b1, 1'b0, W'(d));
    for (int d = 0; d < 4; d++) send(1'b1, 1'b1, W'(d));
    send(1'b1, 1'b0, 2'b10);
    send(1'b1, 1'b1, 2'b01);
    send(1'b1, 1'b0, 2'b11);
    send(1'b1, 1'b1, 2'b01);
    idle_random(3);
    send(1'b1, 1'b1, 2'b00);
    idle_random(3);
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [W-1:0] held0 [2];
    logic [W-1:0] held1 [2];
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      held0[k] = '0;
      held1[k] = '0;
    end
    while (!done) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          held0[k] = '0;
          held1[k] = '0;
          compared++;
          if (o0_w[k] !== '0 || o1_w[k] !== '0 || v0_w[k] !== 1'b0 || v1_w[k] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset dut%0d: got o0=%b o1=%b v0=%b v1=%b, want all zero",
                     k, o0_w[k], o1_w[k], v0_w[k], v1_w[k]);
          end
        end else if (v0_w[k] === 1'b1 || v1_w[k] === 1'b1) begin
          compared++;
          if (sbq[k].size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_valid dut%0d: got v0=%b v1=%b, want no strobe",
                     k, v0_w[k], v1_w[k]);
          end else begin
            e = sbq[k].pop_front();
            held0[k] = e.o0;
            held1[k] = e.o1;
            if ({o0_w[k], o1_w[k], v0_w[k], v1_w[k]} !== e) begin
              mismatched++;
              $display("FAIL routed dut%0d t=%0t: got o0=%b o1=%b v0=%b v1=%b, want o0=%b o1=%b v0=%b v1=%b",
                       k, $time, o0_w[k], o1_w[k], v0_w[k], v1_w[k], e.o0, e.o1, e.v0, e.v1);
            end
          end
        end else begin
          compared++;
          if (o0_w[k] !== held0[k] || o1_w[k] !== held1[k] || v0_w[k] !== 1'b0 || v1_w[k] !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_hold dut%0d t=%0t: got o0=%b o1=%b v0=%b v1=%b, want o0=%b o1=%b v0=0 v1=0",
                     k, $time, o0_w[k], o1_w[k], v0_w[k], v1_w[k], held0[k], held1[k]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (sbq[k].size() != 0) begin
        mismatched++;
        $display("FAIL drain dut%0d: got %0d words never delivered, want 0", k, sbq[k].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #5000;
    $display("FAIL timeout: got no completion by t=%0t, want completion", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
